uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 161 ++++++++++++++++
 tb/tb_uart_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding buffer feeding a shift register,
// registered serial output with optional parity and one or two stop bits.
`ifndef UART_FULL_ETU
`define UART_FULL_ETU 9
`endif

module uart_tx #(
    parameter int   DATA_BITS   = 8,
    parameter int   STOP_BITS   = 1,
    parameter logic PARITY_EN   = 1'b1,
    parameter logic PARITY_EVEN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       dout,
    output logic       busy
);

    localparam int ETU = `UART_FULL_ETU;
    localparam int CW  = (ETU < 1) ? 1 : $clog2(ETU + 1);
    localparam logic [7:0] MASK = 8'((9'd1 << DATA_BITS) - 9'd1);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic            stop_q, stop_d;
    logic [7:0]      sh_q, sh_d;
    logic            par_q, par_d;
    logic [7:0]      buf_q, buf_d;
    logic            full_q, full_d;
    logic            ready_q;
    logic            dout_q, dout_d;
    logic            tick, load, accept;

    assign tick   = (cnt_q == CW'(ETU));
    assign accept = din_valid && ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        stop_d  = stop_q;
        sh_d    = sh_q;
        par_d   = par_q;
        dout_d  = 1'b1;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (full_q) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                dout_d = 1'b0;
                if (tick) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            DATA: begin
                dout_d = sh_q[0];
                if (tick) begin
                    cnt_d = '0;
                    sh_d  = sh_q >> 1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = PARITY_EN ? PAR : STOP;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PAR: begin
                dout_d = par_q;
                if (tick) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    stop_d  = 1'b0;
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    if (stop_q == LAST_STOP) begin
                        // back-to-back frames: reload on the last stop edge
                        if (full_q) begin
                            load    = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (load) begin
            sh_d   = buf_q & MASK;
            par_d  = (^(buf_q & MASK)) ^ ~PARITY_EVEN;
            bit_d  = '0;
            stop_d = 1'b0;
            cnt_d  = '0;
        end
    end

    assign full_d = accept ? 1'b1 : (load ? 1'b0 : full_q);
    assign buf_d  = accept ? din : buf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            dout_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            ready_q <= !full_d;
            dout_q  <= dout_d;
        end
    end

    assign din_ready = ready_q;
    assign dout      = dout_q;
    assign busy      = (state_q != IDLE) || full_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four parameterisations, a serial-line
// receiver monitor per instance, and a frame model built from bit lists.
`timescale 1ns/1ps

module tb_uart_tx;

    localparam int DB  [4] = '{8, 8, 8, 7};
    localparam int SB  [4] = '{1, 1, 2, 1};
    localparam int PE  [4] = '{1, 1, 0, 1};
    localparam int PEV [4] = '{1, 0, 1, 1};

    logic       clk, rst;
    logic [7:0] din  [4];
    logic       dv   [4];
    logic       rdy  [4];
    logic       dout [4];
    logic       busy [4];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int epoch = 0;
    int last_start [4];
    int prev_start [4];
    logic [15:0] expq [4][$];

    uart_tx u0 (
        .clk(clk), .rst(rst), .din(din[0]), .din_valid(dv[0]),
        .din_ready(rdy[0]), .dout(dout[0]), .busy(busy[0])
    );
    uart_tx #(.PARITY_EVEN(1'b0)) u1 (
        .clk(clk), .rst(rst), .din(din[1]), .din_valid(dv[1]),
        .din_ready(rdy[1]), .dout(dout[1]), .busy(busy[1])
    );
    uart_tx #(.PARITY_EN(1'b0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .din(din[2]), .din_valid(dv[2]),
        .din_ready(rdy[2]), .dout(dout[2]), .busy(busy[2])
    );
    uart_tx #(.DATA_BITS(7)) u3 (
        .clk(clk), .rst(rst), .din(din[3]), .din_valid(dv[3]),
        .din_ready(rdy[3]), .dout(dout[3]), .busy(busy[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected line bits in time order: start, data LSB first, parity, stops.
    function automatic logic [15:0] frame(int i, logic [7:0] d);
        logic [15:0] f;
        int p, ones;
        f = '0;
        p = 1;
        ones = 0;
        for (int k = 0; k < DB[i]; k++) begin
            f[p] = d[k];
            ones += int'(d[k]);
            p++;
        end
        if (PE[i] != 0) begin
            f[p] = (PEV[i] != 0) ? (ones % 2 == 1) : (ones % 2 == 0);
            p++;
        end
        for (int s = 0; s < SB[i]; s++) begin
            f[p] = 1'b1;
            p++;
        end
        return f;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : mon
        initial begin
            logic [15:0] got;
            int ep, n;
            n = 1 + DB[g] + PE[g] + SB[g];
            last_start[g] = 0;
            prev_start[g] = 0;
            forever begin
                @(negedge clk);
                if (rst === 1'b1 && dout[g] === 1'b0) begin
                    ep = epoch;
                    prev_start[g] = last_start[g];
                    last_start[g] = cyc;
                    got = '0;
                    repeat (4) @(negedge clk);
                    got[0] = dout[g];
                    for (int k = 1; k < n; k++) begin
                        repeat (10) @(negedge clk);
                        got[k] = dout[g];
                    end
                    if (ep == epoch) begin
                        if (expq[g].size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_frame u%0d: got %h expected none",
                                     g, got);
                        end else begin
                            chk($sformatf("frame_u%0d", g), {16'h0, got},
                                {16'h0, expq[g].pop_front()});
                        end
                    end
                end
            end
        end
    end

    // Holds din_valid until the byte is taken; returns the accept cycle.
    task automatic send(int i, logic [7:0] d, output int acc_cyc);
        int t;
        logic r, acc;
        t = 0;
        acc = 1'b0;
        din[i] = d;
        dv[i] = 1'b1;
        while (!acc && t < 3000) begin
            r = rdy[i];
            @(posedge clk);
            if (r === 1'b1) acc = 1'b1;
            #1;
            t++;
        end
        dv[i] = 1'b0;
        acc_cyc = cyc;
        if (acc) expq[i].push_back(frame(i, d));
        else chk($sformatf("accept_timeout_u%0d", i), 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int t, pend;
        t = 0;
        pend = 1;
        while (pend != 0 && t < 6000) begin
            pend = 0;
            for (int i = 0; i < 4; i++)
                pend += expq[i].size() + int'(busy[i] !== 1'b0);
            @(posedge clk);
            #1;
            t++;
        end
        repeat (20) @(posedge clk);
        #1;
        chk("drain_pending", 32'(pend), 32'd0);
    endtask

    initial begin
        int a1, a2, tmp, hits;
        for (int i = 0; i < 4; i++) begin
            din[i] = 8'h00;
            dv[i] = 1'b0;
        end
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_dout_u%0d", i), 32'(dout[i]), 32'd1);
            chk($sformatf("rst_ready_u%0d", i), 32'(rdy[i]), 32'd0);
            chk($sformatf("rst_busy_u%0d", i), 32'(busy[i]), 32'd0);
        end
        rst = 1'b1;
        #1 chk("ready_before_edge", 32'(rdy[0]), 32'd0);
        @(posedge clk);
        #1 chk("ready_first_edge", 32'(rdy[0]), 32'd1);

        // Latency and frame of 0x55 on the default instance
        send(0, 8'h55, a1);
        chk("ready_drop", 32'(rdy[0]), 32'd0);
        chk("busy_on_accept", 32'(busy[0]), 32'd1);
        @(posedge clk);
        #1 chk("dout_n1", 32'(dout[0]), 32'd1);
        @(posedge clk);
        #1 chk("dout_n2_start", 32'(dout[0]), 32'd0);
        repeat (120) @(posedge clk);
        #1;
        chk("busy_after_frame", 32'(busy[0]), 32'd0);
        chk("ready_after_frame", 32'(rdy[0]), 32'd1);

        send(1, 8'h01, tmp);
        send(2, 8'hA3, tmp);
        send(3, 8'h80, tmp);
        drain();

        // Back-to-back frames with no idle gap
        send(0, 8'h12, a1);
        send(0, 8'h34, a2);
        chk("second_accept_delay", 32'(a2 - a1 <= 3), 32'd1);
        repeat (130) @(posedge clk);
        #1;
        chk("zero_gap", 32'(last_start[0] - prev_start[0]), 32'd110);
        drain();

        // Valid while buffer full is ignored
        send(0, 8'h11, tmp);
        send(0, 8'h22, tmp);
        din[0] = 8'hFF;
        dv[0] = 1'b1;
        hits = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (rdy[0] !== 1'b0) hits++;
        end
        dv[0] = 1'b0;
        chk("full_ignores_valid", 32'(hits), 32'd0);
        drain();

        // Reset in the middle of data bit 3, with a byte buffered
        send(0, 8'h0F, a1);
        send(0, 8'h77, tmp);
        repeat (a1 + 44 - cyc) @(posedge clk);
        #3;
        rst = 1'b0;
        epoch++;
        expq[0].delete();
        #1;
        chk("abort_dout", 32'(dout[0]), 32'd1);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_ready", 32'(rdy[0]), 32'd0);
        #20 rst = 1'b1;
        hits = 0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (dout[0] !== 1'b1) hits++;
        end
        chk("no_resume", 32'(hits), 32'd0);
        send(0, 8'h3C, tmp);
        drain();

        // Randomised traffic across all parameterisations
        for (int r = 0; r < 16; r++) begin
            send(int'($urandom_range(0, 3)), 8'($urandom), tmp);
            repeat ($urandom_range(0, 150)) @(posedge clk);
            #1;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
